switch_allocator: RTL
=====================

# switch_allocator

Per-output packet allocator for the chiplet switch crossbar. Each output port grants its crossbar path to one input at a time with round-robin fairness. The grant is held from head flit to tail flit (wormhole), and a flit is forwarded only while the downstream buffer has credits. The block sits between the input buffers and the crossbar mux selects.

## Interface
- NUM_IN, default 4: number of input ports, ≥2.
- NUM_OUT, default 4: number of output ports, ≥1.
- CREDITS, default 8: downstream buffer depth per output; also the credit reset value.
- CLK  in  1: switch clock.
- nRST  in  1: reset, asynchronous, active-low.
- req_valid  in  NUM_IN: input i has a flit at the head of its buffer.
- req_dest  in  NUM_IN×$clog2(NUM_OUT): destination output of input i's flit; stable while req_valid is high.
- req_tail  in  NUM_IN: input i's head flit is the packet tail. A single-flit packet has head and tail set together.
- credit_ret  in  NUM_OUT: one downstream buffer slot freed at output o this cycle.
- grant  out  NUM_IN: input i's flit is transferred this cycle; the input buffer pops on it.
- out_valid  out  NUM_OUT: output o carries a flit this cycle.
- out_sel  out  NUM_OUT×$clog2(NUM_IN): input index driving output o; meaningful only when out_valid[o] is high.

## Operation
- Per-output FSM with two states:
  - IDLE: no owner.
  - LOCKED: owned by owner[o].
- IDLE, allocation:
  - Candidates are inputs i with req_valid[i] && req_dest[i]==o.
  - Winner is the first candidate strictly after last[o], searched in increasing index order with wrap-around.
  - The winner is registered into owner[o], last[o] ← winner, and the FSM goes to LOCKED.
  - No flit transfers in the allocation cycle.
  - With no candidates the FSM stays in IDLE and last[o] is unchanged.
- LOCKED, transfer:
  - Condition: req_valid[owner] && credits[o]>0.
  - On transfer: out_valid[o]=1, out_sel[o]=owner, grant[owner]=1, credits decrement.
  - A transfer with req_tail[owner] returns the FSM to IDLE next cycle.
  - A stall (no valid, or zero credits) holds LOCKED with no timeout.
- An input is owned by at most one output, because req_dest is single-valued and stable. grant[i] is the OR over outputs.
- Credits, per output, range 0..CREDITS, width $clog2(CREDITS+1):
  - Transfer and credit_ret in the same cycle: count unchanged.
  - credit_ret alone: increment, saturating at CREDITS.
  - Transfer only ever occurs with credits>0, so the counter never underflows.
- All outputs are independent; a stall at one output never affects another.

## Timing
- grant, out_valid and out_sel are combinational from registered state (FSM, owner, credits) and current req_valid. There is no comb path from req_tail or credit_ret to outputs.
- Allocation latency: request visible in cycle t → first transfer in cycle t+1 at earliest.
- Throughput: 1 flit/cycle/output while locked, valid and credited.
- Back-to-back packets to the same output: tail transfers in cycle t, IDLE in t+1 (allocation), next head transfers in t+2. This gives one bubble per packet.
- Credit returned in cycle t is usable in cycle t+1.
- Reset values:
  - FSM = IDLE.
  - owner = 0.
  - last = NUM_IN-1, so input 0 wins first.
  - credits = CREDITS.
  - grant, out_valid and out_sel all 0.
- Reset mid-packet abandons the lock immediately. Flushing the partial packet upstream is the system's responsibility.

## Configuration
- SWITCH_ALLOC_STATS_EN defined:
  - Adds output port pkt_count (NUM_OUT×16).
  - pkt_count increments per output on every tail transfer, saturating at 16'hFFFF.
  - Resets to 0.
- SWITCH_ALLOC_STATS_EN undefined: port and counters are absent. Allocation behaviour is identical.

## Structure
- Package switch_pkg:
  - Typedefs in_idx_t ($clog2(NUM_IN)), out_idx_t ($clog2(NUM_OUT)) and credit_t.
  - alloc_state_t enum {IDLE, LOCKED}.
- Sub-module alloc_rr_arbiter, one instance per output: combinational round-robin pick from a NUM_IN request vector and a last pointer, giving winner index and found flag. The FSM, credits and pointer registers live in switch_allocator.

## Test plan
- Reset, then input 0 sends a 1-flit packet to output 2 → allocation cycle 1, transfer cycle 2 (grant[0]=1, out_sel[2]=0), output 2 back in IDLE cycle 3, credits[2]=7.
- Inputs 0, 1, 3 each send 3-flit packets to output 1 continuously → packet order 0,1,3,0,… with no interleaved flits and one bubble between packets.
- CREDITS=2, a 4-flit packet with no credit_ret → 2 transfers, then a stall with LOCKED held. A credit_ret pulse → exactly one more transfer the following cycle.
- Simultaneous transfer and credit_ret at credits=1 → credits stay 1. credit_ret at credits=CREDITS → stays CREDITS.
- Inputs 0→out0 and 1→out1 concurrently → both grant every cycle, independent.
- Assert nRST mid-packet → all outputs 0 immediately. After release input 0 wins first. With STATS_EN, pkt_count reads 0 and then counts tails.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types for the switch allocator: index/credit typedefs sized for the
// default configuration and the per-output allocation FSM state encoding.
package switch_pkg;

  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_CREDITS = 8;

  typedef logic [$clog2(DEF_NUM_IN)-1:0]    in_idx_t;
  typedef logic [$clog2(DEF_NUM_OUT)-1:0]   out_idx_t;
  typedef logic [$clog2(DEF_CREDITS+1)-1:0] credit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/alloc_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after 'last',
// scanning upward with wrap-around. 'found' is low when nothing requests.
module alloc_rr_arbiter #(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] last,
  output logic [$clog2(NUM_IN)-1:0] winner,
  output logic                      found
);

  localparam int IW = $clog2(NUM_IN);

  // Scan from the farthest offset down to the nearest so the nearest hit wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_IN;
      if (req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole allocator with round-robin fairness and credit-based
// flow control. Each output owns an IDLE/LOCKED FSM, an owner, a round-robin
// pointer and a credit counter; outputs are fully independent.
// Optional: define SWITCH_ALLOC_STATS_EN to add per-output tail counters
// on port pkt_count.
module switch_allocator
  import switch_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4,
  parameter int CREDITS = 8,
  localparam int IW = $clog2(NUM_IN),
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NUM_IN-1:0]     req_valid,
  input  logic [NUM_IN*OW-1:0]  req_dest,
  input  logic [NUM_IN-1:0]     req_tail,
  input  logic [NUM_OUT-1:0]    credit_ret,
  output logic [NUM_IN-1:0]     grant,
  output logic [NUM_OUT-1:0]    out_valid,
`ifdef SWITCH_ALLOC_STATS_EN
  output logic [NUM_OUT*IW-1:0] out_sel,
  output logic [NUM_OUT*16-1:0] pkt_count
`else
  output logic [NUM_OUT*IW-1:0] out_sel
`endif
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_OUT*NUM_IN-1:0] gnt_flat;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      alloc_state_t      state_reg, state_next;
      logic [IW-1:0]     owner_reg, owner_next;
      logic [IW-1:0]     last_reg, last_next;
      logic [CW-1:0]     credits_reg, credits_next;
      logic [NUM_IN-1:0] cand;
      logic [IW-1:0]     rr_winner;
      logic              rr_found;
      logic              xfer;
      logic [NUM_IN-1:0] gnt_o;

      for (gj = 0; gj < NUM_IN; gj++) begin : g_cand
        assign cand[gj] = req_valid[gj] && (req_dest[gj*OW +: OW] == OW'(gi));
      end

      alloc_rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req    (cand),
        .last   (last_reg),
        .winner (rr_winner),
        .found  (rr_found)
      );

      // A flit moves when the owner presents one and downstream has room.
      always_comb begin
        xfer  = (state_reg == LOCKED) && req_valid[owner_reg] && (credits_reg != '0);
        gnt_o = '0;
        if (xfer) gnt_o[owner_reg] = 1'b1;
      end

      assign out_valid[gi]            = xfer;
      assign out_sel[gi*IW +: IW]     = xfer ? owner_reg : '0;
      assign gnt_flat[gi*NUM_IN +: NUM_IN] = gnt_o;

      // Next-state: allocate in IDLE, release on the tail transfer.
      always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        case (state_reg)
          IDLE: begin
            if (rr_found) begin
              state_next = LOCKED;
              owner_next = rr_winner;
              last_next  = rr_winner;
            end
          end
          LOCKED: begin
            if (xfer && req_tail[owner_reg]) state_next = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end

      // Credit bookkeeping: a return and a transfer in one cycle cancel out.
      always_comb begin
        credits_next = credits_reg;
        if (xfer && !credit_ret[gi])
          credits_next = credits_reg - 1'b1;
        else if (!xfer && credit_ret[gi] && (credits_reg != CW'(CREDITS)))
          credits_next = credits_reg + 1'b1;
      end

      // State, owner, pointer and credit registers.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          state_reg   <= IDLE;
          owner_reg   <= '0;
          last_reg    <= IW'(NUM_IN - 1);
          credits_reg <= CW'(CREDITS);
        end else begin
          state_reg   <= state_next;
          owner_reg   <= owner_next;
          last_reg    <= last_next;
          credits_reg <= credits_next;
        end
      end

`ifdef SWITCH_ALLOC_STATS_EN
      logic [15:0] pkt_reg;

      // Count completed packets (tail transfers), saturating.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
          pkt_reg <= '0;
        else if (xfer && req_tail[owner_reg] && (pkt_reg != 16'hFFFF))
          pkt_reg <= pkt_reg + 16'd1;
      end

      assign pkt_count[gi*16 +: 16] = pkt_reg;
`endif
    end
  endgenerate

  // An input is owned by at most one output, so OR-ing per-output grants is safe.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_OUT; o++) grant = grant | gnt_flat[o*NUM_IN +: NUM_IN];
  end

endmodule
